// File: rtl/dm_cmd_responder_pkg.sv
// Shared definitions for the DataMover command responder: command/status field
// positions, FSM state encodings and the status-byte builder.
package dm_cmd_responder_pkg;

  localparam int CMD_W  = 72;
  localparam int DATA_W = 128;
  localparam int KEEP_W = 16;
  localparam int STS_W  = 8;
  localparam int BEAT_W = 20;
  localparam int BTT_W  = 23;

  localparam int BTT_LSB  = 0;
  localparam int TYPE_BIT = 23;
  localparam int DSA_LSB  = 24;
  localparam int EOF_BIT  = 30;
  localparam int DRR_BIT  = 31;
  localparam int ADDR_LSB = 32;
  localparam int TAG_LSB  = 64;

  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_STS = 2'd2} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_DATA = 2'd1, RD_STS = 2'd2} rd_state_t;

  function automatic logic [STS_W-1:0] make_sts(input logic decerr, input logic interr,
                                                 input logic [3:0] tag);
    logic [STS_W-1:0] s;
    s             = '0;
    s[STS_OKAY]   = !(decerr || interr);
    s[STS_SLVERR] = 1'b0;
    s[STS_DECERR] = decerr;
    s[STS_INTERR] = interr;
    s[3:0]        = tag;
    return s;
  endfunction

endpackage

// File: rtl/dm_cmd_responder_decode.sv
// Combinational command decode: field extraction, beat count and the
// address-range / malformed-command checks shared by both channels.
module dm_cmd_decode
  import dm_cmd_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          AW        = 16
) (
  input  logic [CMD_W-1:0]  cmd,
  output logic [AW-1:0]     index,
  output logic [BEAT_W-1:0] beats,
  output logic [3:0]        tag,
  output logic              eof,
  output logic              decerr,
  output logic              interr
);

  logic [BTT_W-1:0] btt;
  logic [31:0]      addr;
  logic [32:0]      offset;
  logic [23:0]      beats_full;
  logic [33:0]      span;
  logic             unused_bits;

  always_comb begin
    btt        = cmd[BTT_LSB +: BTT_W];
    addr       = cmd[ADDR_LSB +: 32];
    tag        = cmd[TAG_LSB +: 4];
    eof        = cmd[EOF_BIT];
    beats_full = ({1'b0, btt} + 24'd15) >> 4;
    beats      = beats_full[BEAT_W-1:0];
    // The borrow bit of the subtraction flags addresses below the window.
    offset     = {1'b0, addr} - {1'b0, BASE_ADDR};
    index      = offset[4 +: AW];
    span       = {6'b0, offset[31:4]} + {14'b0, beats};
    decerr     = offset[32] || (span > 34'(MEM_WORDS));
    interr     = (btt == '0) || !cmd[TYPE_BIT];
    unused_bits = ^{cmd[71:68], cmd[DRR_BIT], cmd[DSA_LSB +: 6], offset[3:0], beats_full[23:20]};
  end

endmodule

// File: rtl/dm_cmd_responder.sv
// DataMover + memory stand-in: S2MM commands fill a word memory, MM2S commands
// stream it back, each channel returning an 8-bit status.
module dm_cmd_responder
  import dm_cmd_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_GAP    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axis_s2mm_cmd_tvalid,
  output logic              s_axis_s2mm_cmd_tready,
  input  logic [CMD_W-1:0]  s_axis_s2mm_cmd_tdata,
  input  logic [DATA_W-1:0] s_axis_s2mm_tdata,
  input  logic [KEEP_W-1:0] s_axis_s2mm_tkeep,
  input  logic              s_axis_s2mm_tlast,
  input  logic              s_axis_s2mm_tvalid,
  output logic              s_axis_s2mm_tready,
  output logic [STS_W-1:0]  m_axis_s2mm_sts_tdata,
  output logic              m_axis_s2mm_sts_tvalid,
  input  logic              m_axis_s2mm_sts_tready,
  output logic              m_axis_s2mm_sts_tlast,
  output logic              m_axis_s2mm_sts_tkeep,
  input  logic              s_axis_mm2s_cmd_tvalid,
  output logic              s_axis_mm2s_cmd_tready,
  input  logic [CMD_W-1:0]  s_axis_mm2s_cmd_tdata,
  output logic [DATA_W-1:0] m_axis_mm2s_tdata,
  output logic [KEEP_W-1:0] m_axis_mm2s_tkeep,
  output logic              m_axis_mm2s_tlast,
  output logic              m_axis_mm2s_tvalid,
  input  logic              m_axis_mm2s_tready,
  output logic [STS_W-1:0]  m_axis_mm2s_sts_tdata,
  output logic              m_axis_mm2s_sts_tvalid,
  input  logic              m_axis_mm2s_sts_tready,
  output logic              m_axis_mm2s_sts_tlast,
  output logic              m_axis_mm2s_sts_tkeep,
  output logic [3:0]        status_dm
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int GAP_W = (RD_GAP > 1) ? $clog2(RD_GAP + 1) : 1;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [AW-1:0]     wdec_index, rdec_index;
  logic [BEAT_W-1:0] wdec_beats, rdec_beats;
  logic [3:0]        wdec_tag, rdec_tag;
  logic              wdec_eof, rdec_eof;
  logic              wdec_decerr, rdec_decerr, wdec_interr, rdec_interr;

  dm_cmd_decode #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR), .AW(AW)) u_wr_decode (
    .cmd(s_axis_s2mm_cmd_tdata), .index(wdec_index), .beats(wdec_beats), .tag(wdec_tag),
    .eof(wdec_eof), .decerr(wdec_decerr), .interr(wdec_interr)
  );

  dm_cmd_decode #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR), .AW(AW)) u_rd_decode (
    .cmd(s_axis_mm2s_cmd_tdata), .index(rdec_index), .beats(rdec_beats), .tag(rdec_tag),
    .eof(rdec_eof), .decerr(rdec_decerr), .interr(rdec_interr)
  );

  wr_state_t         wr_state;
  logic [AW-1:0]     wr_idx;
  logic [BEAT_W-1:0] wr_cnt, wr_beats;
  logic [3:0]        wr_tag;
  logic              wr_decerr, wr_fire, unused_wr_eof;

  rd_state_t         rd_state;
  logic [AW-1:0]     rd_idx;
  logic [BEAT_W-1:0] rd_cnt, rd_beats;
  logic [3:0]        rd_tag;
  logic              rd_eof, rd_fire;
  logic [GAP_W-1:0]  gap_cnt;

  assign wr_fire       = s_axis_s2mm_tvalid && s_axis_s2mm_tready;
  assign rd_fire       = m_axis_mm2s_tvalid && m_axis_mm2s_tready;
  assign unused_wr_eof = wdec_eof;

  assign m_axis_mm2s_tkeep      = {KEEP_W{1'b1}};
  assign m_axis_s2mm_sts_tlast  = m_axis_s2mm_sts_tvalid;
  assign m_axis_s2mm_sts_tkeep  = 1'b1;
  assign m_axis_mm2s_sts_tlast  = m_axis_mm2s_sts_tvalid;
  assign m_axis_mm2s_sts_tkeep  = 1'b1;
  assign status_dm              = {rd_state, wr_state};

  // Out-of-range commands still drain their beats but never touch memory.
  always_ff @(posedge clk) begin
    if (wr_fire && !wr_decerr) begin
      for (int b = 0; b < KEEP_W; b++) begin
        if (s_axis_s2mm_tkeep[b]) mem[wr_idx][b*8 +: 8] <= s_axis_s2mm_tdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state               <= WR_IDLE;
      s_axis_s2mm_cmd_tready <= 1'b0;
      s_axis_s2mm_tready     <= 1'b0;
      m_axis_s2mm_sts_tvalid <= 1'b0;
      m_axis_s2mm_sts_tdata  <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          s_axis_s2mm_cmd_tready <= 1'b1;
          if (s_axis_s2mm_cmd_tvalid && s_axis_s2mm_cmd_tready) begin
            s_axis_s2mm_cmd_tready <= 1'b0;
            wr_idx    <= wdec_index;
            wr_cnt    <= '0;
            wr_beats  <= wdec_beats;
            wr_tag    <= wdec_tag;
            wr_decerr <= wdec_decerr;
            if (wdec_interr) begin
              wr_state               <= WR_STS;
              m_axis_s2mm_sts_tvalid <= 1'b1;
              m_axis_s2mm_sts_tdata  <= make_sts(wdec_decerr, 1'b1, wdec_tag);
            end else begin
              wr_state           <= WR_DATA;
              s_axis_s2mm_tready <= 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (wr_fire) begin
            wr_idx <= wr_idx + AW'(1);
            wr_cnt <= wr_cnt + BEAT_W'(1);
            if ((wr_cnt + BEAT_W'(1) == wr_beats) || s_axis_s2mm_tlast) begin
              s_axis_s2mm_tready     <= 1'b0;
              wr_state               <= WR_STS;
              m_axis_s2mm_sts_tvalid <= 1'b1;
              m_axis_s2mm_sts_tdata  <= make_sts(wr_decerr, 1'b0, wr_tag);
            end
          end
        end
        WR_STS: begin
          if (m_axis_s2mm_sts_tready) begin
            m_axis_s2mm_sts_tvalid <= 1'b0;
            s_axis_s2mm_cmd_tready <= 1'b1;
            wr_state               <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read data is registered; the next word loads on the same edge as the
  // handshake so a zero gap streams without bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state               <= RD_IDLE;
      s_axis_mm2s_cmd_tready <= 1'b0;
      m_axis_mm2s_tvalid     <= 1'b0;
      m_axis_mm2s_tdata      <= '0;
      m_axis_mm2s_tlast      <= 1'b0;
      m_axis_mm2s_sts_tvalid <= 1'b0;
      m_axis_mm2s_sts_tdata  <= '0;
      gap_cnt                <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          s_axis_mm2s_cmd_tready <= 1'b1;
          if (s_axis_mm2s_cmd_tvalid && s_axis_mm2s_cmd_tready) begin
            s_axis_mm2s_cmd_tready <= 1'b0;
            rd_cnt   <= '0;
            rd_beats <= rdec_beats;
            rd_tag   <= rdec_tag;
            rd_eof   <= rdec_eof;
            if (rdec_decerr || rdec_interr) begin
              rd_state               <= RD_STS;
              m_axis_mm2s_sts_tvalid <= 1'b1;
              m_axis_mm2s_sts_tdata  <= make_sts(rdec_decerr, rdec_interr, rdec_tag);
            end else begin
              rd_state           <= RD_DATA;
              m_axis_mm2s_tvalid <= 1'b1;
              m_axis_mm2s_tdata  <= mem[rdec_index];
              m_axis_mm2s_tlast  <= rdec_eof && (rdec_beats == BEAT_W'(1));
              rd_idx             <= rdec_index + AW'(1);
            end
          end
        end
        RD_DATA: begin
          if (rd_fire) begin
            rd_cnt <= rd_cnt + BEAT_W'(1);
            if (rd_cnt + BEAT_W'(1) == rd_beats) begin
              m_axis_mm2s_tvalid     <= 1'b0;
              m_axis_mm2s_tlast      <= 1'b0;
              rd_state               <= RD_STS;
              m_axis_mm2s_sts_tvalid <= 1'b1;
              m_axis_mm2s_sts_tdata  <= make_sts(1'b0, 1'b0, rd_tag);
            end else if (RD_GAP == 0) begin
              m_axis_mm2s_tdata <= mem[rd_idx];
              m_axis_mm2s_tlast <= rd_eof && (rd_cnt + BEAT_W'(2) == rd_beats);
              rd_idx            <= rd_idx + AW'(1);
            end else begin
              m_axis_mm2s_tvalid <= 1'b0;
              gap_cnt            <= GAP_W'(RD_GAP - 1);
            end
          end else if (!m_axis_mm2s_tvalid) begin
            if (gap_cnt == '0) begin
              m_axis_mm2s_tvalid <= 1'b1;
              m_axis_mm2s_tdata  <= mem[rd_idx];
              m_axis_mm2s_tlast  <= rd_eof && (rd_cnt + BEAT_W'(1) == rd_beats);
              rd_idx             <= rd_idx + AW'(1);
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
        end
        RD_STS: begin
          if (m_axis_mm2s_sts_tready) begin
            m_axis_mm2s_sts_tvalid <= 1'b0;
            s_axis_mm2s_cmd_tready <= 1'b1;
            rd_state               <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule
